dsram_arbiter: RTL and testbench

Shares the single synchronous data SRAM port between the CPU load/store path (driven from EX, consumed in MEM) and an auxiliary master (debug/DMA). The CPU has priority. A per-request wait counter bounds auxiliary starvation by forcing one auxiliary slot, during which the CPU is stalled through the stall controller. The block sits between EX/MEM and the top-level `data_sram_*` pins.

---
 rtl/dsram_arbiter_pkg.sv | 35 +++
 rtl/dsram_wait_ctr.sv | 34 +++
 rtl/dsram_arbiter.sv | 84 ++++++++
 tb/tb_dsram_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dsram_arbiter_pkg.sv
// Shared types and constants for the data-SRAM arbiter between the CPU
// load/store path and the auxiliary (debug/DMA) master.
package dsram_arbiter_pkg;

    localparam int DSRAM_WAIT_WD = 4;
    localparam int DSRAM_SRAM_WD = 69;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dsram_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_AUX  = 2'd2
    } dsram_src_e;

    function automatic dsram_req_t make_req(
        input logic        en,
        input logic [3:0]  wen,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        dsram_req_t r;
        r.en    = en;
        r.wen   = wen;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dsram_wait_ctr.sv
// Saturating wait counter with synchronous clear; o_sat flags the
// saturation value so the arbiter can force an auxiliary slot.
module dsram_wait_ctr
    import dsram_arbiter_pkg::*;
#(
    parameter int unsigned SAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [DSRAM_WAIT_WD-1:0] SAT_V = DSRAM_WAIT_WD'(SAT);

    logic [DSRAM_WAIT_WD-1:0] r_cnt;

    // Count refused cycles; clear wins, saturation holds the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {DSRAM_WAIT_WD{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {DSRAM_WAIT_WD{1'b0}};
        end else if (i_inc && (r_cnt != SAT_V)) begin
            r_cnt <= r_cnt + DSRAM_WAIT_WD'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_sat = (r_cnt == SAT_V);

endmodule

// File: rtl/dsram_arbiter.sv
// Data-SRAM port arbiter: CPU has priority, the auxiliary master is
// forcibly granted after MAX_WAIT refused cycles, stalling the CPU.
module dsram_arbiter
    import dsram_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        stallreq_dsram,
    input  logic        aux_req,
    input  logic [3:0]  aux_wen,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    logic       w_sat;
    logic       w_aux_gnt;
    dsram_src_e w_src;
    dsram_req_t w_req;
    logic       r_aux_rvalid;

    assign w_aux_gnt = aux_req && (!cpu_en || w_sat);

    dsram_wait_ctr #(
        .SAT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (aux_req && !w_aux_gnt),
        .i_clr (!aux_req || w_aux_gnt),
        .o_sat (w_sat)
    );

    // Select the port owner and build the SRAM request for this cycle.
    always_comb begin
        w_src = SRC_NONE;
        w_req = make_req(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
        if (w_aux_gnt) begin
            w_src = SRC_AUX;
        end else if (cpu_en) begin
            w_src = SRC_CPU;
        end else begin
            w_src = SRC_NONE;
        end
        case (w_src)
            SRC_AUX:  w_req = make_req(1'b1, aux_wen, aux_addr, aux_wdata);
            SRC_CPU:  w_req = make_req(1'b1, cpu_wen, cpu_addr, cpu_wdata);
            SRC_NONE: w_req = make_req(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
            default:  w_req = make_req(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
        endcase
    end

    // Auxiliary read response is valid the cycle after a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aux_rvalid <= 1'b0;
        end else begin
            r_aux_rvalid <= w_aux_gnt && (aux_wen == 4'b0000);
        end
    end

    assign aux_gnt         = w_aux_gnt;
    assign stallreq_dsram  = cpu_en && w_aux_gnt;
    assign data_sram_en    = w_req.en;
    assign data_sram_wen   = w_req.wen;
    assign data_sram_addr  = w_req.addr;
    assign data_sram_wdata = w_req.wdata;
    assign aux_rvalid      = r_aux_rvalid;
    assign aux_rdata       = r_aux_rvalid ? data_sram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Self-checking bench: two arbiters (MAX_WAIT=4 and MAX_WAIT=0) share stimulus
// and are compared every cycle against a refusal-count reference model.
module tb_dsram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        aux_req;
    logic [3:0]  aux_wen;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [31:0] sram_rdata;

    logic [1:0]  gnt, stall, s_en, rv;
    logic [3:0]  s_wen   [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [31:0] a_rdata [2];

    int n_tests = 0;
    int n_fail  = 0;
    int refused [2];
    bit rvm     [2];
    bit egv     [2];
    int mw      [2];

    always #5 clk = ~clk;

    dsram_arbiter #(.MAX_WAIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .stallreq_dsram(stall[0]),
        .aux_req(aux_req), .aux_wen(aux_wen), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(gnt[0]), .aux_rvalid(rv[0]), .aux_rdata(a_rdata[0]),
        .data_sram_en(s_en[0]), .data_sram_wen(s_wen[0]), .data_sram_addr(s_addr[0]),
        .data_sram_wdata(s_wdata[0]), .data_sram_rdata(sram_rdata)
    );

    dsram_arbiter #(.MAX_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .stallreq_dsram(stall[1]),
        .aux_req(aux_req), .aux_wen(aux_wen), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(gnt[1]), .aux_rvalid(rv[1]), .aux_rdata(a_rdata[1]),
        .data_sram_en(s_en[1]), .data_sram_wen(s_wen[1]), .data_sram_addr(s_addr[1]),
        .data_sram_wdata(s_wdata[1]), .data_sram_rdata(sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the model for the current cycle.
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic        eg, ee;
            logic [3:0]  ew;
            logic [31:0] ea, ed;
            if (rst) begin
                refused[k] = 0;
                rvm[k]     = 1'b0;
            end
            eg = aux_req && (!cpu_en || (refused[k] >= mw[k]));
            egv[k] = eg;
            if (eg) begin
                ee = 1'b1; ew = aux_wen; ea = aux_addr; ed = aux_wdata;
            end else if (cpu_en) begin
                ee = 1'b1; ew = cpu_wen; ea = cpu_addr; ed = cpu_wdata;
            end else begin
                ee = 1'b0; ew = 4'h0; ea = 32'h0; ed = 32'h0;
            end
            chk($sformatf("m%0d_gnt", mw[k]),    {31'h0, gnt[k]},   {31'h0, eg});
            chk($sformatf("m%0d_stall", mw[k]),  {31'h0, stall[k]}, {31'h0, cpu_en && eg});
            chk($sformatf("m%0d_en", mw[k]),     {31'h0, s_en[k]},  {31'h0, ee});
            chk($sformatf("m%0d_wen", mw[k]),    {28'h0, s_wen[k]}, {28'h0, ew});
            chk($sformatf("m%0d_addr", mw[k]),   s_addr[k],  ea);
            chk($sformatf("m%0d_wdata", mw[k]),  s_wdata[k], ed);
            chk($sformatf("m%0d_rvalid", mw[k]), {31'h0, rv[k]},    {31'h0, rvm[k]});
            chk($sformatf("m%0d_rdata", mw[k]),  a_rdata[k], rvm[k] ? sram_rdata : 32'h0);
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic adv();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rvm[k]     = 1'b0;
                refused[k] = 0;
            end else begin
                rvm[k]     = egv[k] && (aux_wen == 4'h0);
                refused[k] = (aux_req && !egv[k]) ? refused[k] + 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        mw[0] = 4; mw[1] = 0;
        refused[0] = 0; refused[1] = 0;
        rvm[0] = 1'b0; rvm[1] = 1'b0;
        rst = 1'b1;
        cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        aux_req = 1'b0; aux_wen = 4'h0; aux_addr = 32'h0; aux_wdata = 32'h0;
        sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        settle();
        chk("reset_rvalid", {31'h0, rv[0]}, 32'h0);
        chk("reset_rdata", a_rdata[0], 32'h0);
        adv();
        rst = 1'b0;

        cpu_en = 1'b1; cpu_addr = 32'h100;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("cpu_only_en", {31'h0, s_en[0]}, 32'h1);
            chk("cpu_only_addr", s_addr[0], 32'h100);
            chk("cpu_only_stall", {31'h0, stall[0]}, 32'h0);
            chk("cpu_only_rvalid", {31'h0, rv[0]}, 32'h0);
            adv();
        end

        cpu_en = 1'b0; aux_req = 1'b1; aux_addr = 32'h200; aux_wen = 4'h0;
        settle();
        chk("aux_rd_gnt", {31'h0, gnt[0]}, 32'h1);
        chk("aux_rd_stall", {31'h0, stall[0]}, 32'h0);
        adv();
        aux_req = 1'b0; sram_rdata = 32'hDEADBEEF;
        settle();
        chk("aux_rd_rvalid", {31'h0, rv[0]}, 32'h1);
        chk("aux_rd_rdata", a_rdata[0], 32'hDEADBEEF);
        adv();

        cpu_en = 1'b1; cpu_addr = 32'h104; aux_req = 1'b1; aux_addr = 32'h300;
        for (int c = 1; c <= 6; c++) begin
            settle();
            chk($sformatf("starve_gnt_c%0d", c), {31'h0, gnt[0]}, {31'h0, c == 5});
            chk($sformatf("starve_stall_c%0d", c), {31'h0, stall[0]}, {31'h0, c == 5});
            chk($sformatf("mw0_gnt_c%0d", c), {31'h0, gnt[1]}, 32'h1);
            chk($sformatf("mw0_stall_c%0d", c), {31'h0, stall[1]}, 32'h1);
            if (c == 6) chk("starve_regrant_addr", s_addr[0], 32'h104);
            adv();
        end

        cpu_en = 1'b0; aux_req = 1'b1; aux_wen = 4'b0011; aux_wdata = 32'h1234;
        settle();
        chk("aux_wr_wen", {28'h0, s_wen[0]}, 32'h3);
        chk("aux_wr_wdata", s_wdata[0], 32'h1234);
        adv();
        aux_req = 1'b0; aux_wen = 4'h0;
        settle();
        chk("aux_wr_no_rvalid", {31'h0, rv[0]}, 32'h0);
        adv();

        cpu_en = 1'b1; aux_req = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        aux_req = 1'b0;
        settle();
        chk("release_no_gnt", {31'h0, gnt[0]}, 32'h0);
        adv();
        aux_req = 1'b1;
        settle();
        chk("release_cleared", {31'h0, gnt[0]}, 32'h0);
        adv();

        cpu_en = 1'b0; aux_req = 1'b1; aux_wen = 4'h0; aux_addr = 32'h400;
        cyc();
        aux_req = 1'b0; rst = 1'b1; sram_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("rst_mid_rvalid", {31'h0, rv[0]}, 32'h0);
            chk("rst_mid_rdata", a_rdata[0], 32'h0);
            adv();
        end
        rst = 1'b0; aux_req = 1'b1; aux_addr = 32'h404;
        settle();
        chk("post_rst_gnt", {31'h0, gnt[0]}, 32'h1);
        adv();
        aux_req = 1'b0; sram_rdata = 32'h0BAD_F00D;
        settle();
        chk("post_rst_rdata", a_rdata[0], 32'h0BAD_F00D);
        adv();

        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            cpu_en     = $urandom_range(0, 1) == 1;
            cpu_wen    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            cpu_addr   = $urandom;
            cpu_wdata  = $urandom;
            aux_req    = ($urandom_range(0, 3) != 0);
            aux_wen    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            aux_addr   = $urandom;
            aux_wdata  = $urandom;
            sram_rdata = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
